// File: rtl/apb_initiator.sv
// APB4 requester: converts one valid/ready request into a single SETUP/ACCESS transfer
// and reports completion, read data and error on a one-cycle response strobe.
module apb_initiator #(
  parameter int XLEN       = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [XLEN-1:0]       ReqWData,
  input  logic [XLEN/8-1:0]     ReqStrb,
  output logic                  RspValid,
  output logic [XLEN-1:0]       RspRData,
  output logic                  RspErr,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [XLEN-1:0]       PWDATA,
  output logic [XLEN/8-1:0]     PSTRB,
  input  logic [XLEN-1:0]       PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  // A zero TIMEOUT still needs a legal one-bit counter, even though it never counts.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WD_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t        state;
  logic [CW-1:0] wd_cnt;
  logic          wd_expire;

  assign ReqReady  = (state == IDLE);
  // The wait cycle that would bring the count up to TIMEOUT is the last one allowed.
  assign wd_expire = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

  // NOTE: every register here is a plain flop with a defined reset value; there is no
  // storage array, so nothing is left uninitialised after PRESETn.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      wd_cnt   <= '0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      PWRITE   <= 1'b0;
      PADDR    <= '0;
      PWDATA   <= '0;
      PSTRB    <= '0;
      RspValid <= 1'b0;
      RspRData <= '0;
      RspErr   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so the default below is simply
      // overridden by the ACCESS branch without any ordering hazard.
      RspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (ReqValid) begin
            PWRITE <= ReqWrite;
            PADDR  <= ReqAddr;
            PWDATA <= ReqWData;
            PSTRB  <= ReqWrite ? ReqStrb : '0;
            PSEL   <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          wd_cnt  <= '0;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            // Completion takes priority over a watchdog expiring in the same cycle.
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            RspValid <= 1'b1;
            RspErr   <= PSLVERR;
            RspRData <= PWRITE ? '0 : PRDATA;
            state    <= IDLE;
          end else if (wd_expire) begin
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            RspValid <= 1'b1;
            RspErr   <= 1'b1;
            RspRData <= '0;
            state    <= IDLE;
          end else if (TIMEOUT != 0) begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
